// File: rtl/keypad_pkg.sv
// Shared keypad definitions: column strobes, key codes, responder states
// and the key-code to column/row map used by scanner and responder.
package keypad_pkg;

   localparam logic [2:0] NO_SCAN = 3'b000;
   localparam logic [2:0] COLUMN1 = 3'b001;
   localparam logic [2:0] COLUMN2 = 3'b010;
   localparam logic [2:0] COLUMN3 = 3'b100;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;

   typedef logic [3:0] key_code_t;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HOLD,
      GAP
   } kp_state_e;

   typedef struct packed {
      logic       valid;
      logic [2:0] col;
      logic [3:0] row;
   } colrow_t;

   function automatic colrow_t key_to_colrow(input key_code_t code);
      colrow_t r;
      r = '0;
      r.valid = 1'b1;
      case (code)
         4'd1:     begin r.col = COLUMN1; r.row = 4'b0001; end
         4'd4:     begin r.col = COLUMN1; r.row = 4'b0010; end
         4'd7:     begin r.col = COLUMN1; r.row = 4'b0100; end
         KEY_STAR: begin r.col = COLUMN1; r.row = 4'b1000; end
         4'd2:     begin r.col = COLUMN2; r.row = 4'b0001; end
         4'd5:     begin r.col = COLUMN2; r.row = 4'b0010; end
         4'd8:     begin r.col = COLUMN2; r.row = 4'b0100; end
         4'd0:     begin r.col = COLUMN2; r.row = 4'b1000; end
         4'd3:     begin r.col = COLUMN3; r.row = 4'b0001; end
         4'd6:     begin r.col = COLUMN3; r.row = 4'b0010; end
         4'd9:     begin r.col = COLUMN3; r.row = 4'b0100; end
         KEY_HASH: begin r.col = COLUMN3; r.row = 4'b1000; end
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/keypad_responder_if.sv
// Press-command handshake between a test sequencer and the keypad responder.
interface keypad_cmd_if
   import keypad_pkg::*;
();
   logic      cmd_valid;
   key_code_t cmd_key;
   logic      cmd_ready;

   modport master (
      output cmd_valid,
      output cmd_key,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_key,
      output cmd_ready
   );
endinterface

// File: rtl/keypad_responder.sv
// Emulates a physical key on the 3x4 keypad matrix: drives the row lines
// when the scanner strobes the pressed key's column. Bounce: KEYPAD_BOUNCE_EN.
module keypad_responder
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES    = 50000,
   parameter int GAP_CYCLES     = 50000,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int BOUNCE_CYCLES  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   keypad_cmd_if.slave      cmd,
   input  logic [2:0]       key_col,
   output logic [3:0]       key_row,
   output logic             busy,
   output logic             done_pulse,
   output logic             err_pulse
);

   localparam int MAX_A   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int MAX_B   = (TIMEOUT_CYCLES > BOUNCE_CYCLES) ? TIMEOUT_CYCLES : BOUNCE_CYCLES;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX) + 1;

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t CNT_TOP   = cnt_t'(CNT_MAX);
   localparam cnt_t HOLD_LAST = cnt_t'(HOLD_CYCLES - 1);
   localparam cnt_t GAP_LAST  = cnt_t'(GAP_CYCLES - 1);
   localparam cnt_t TO_LAST   = cnt_t'(TIMEOUT_CYCLES - 1);

   kp_state_e  state_q, state_d;
   cnt_t       cnt_q, cnt_d, cnt_inc;
   logic [2:0] col_q, col_d;
   logic [3:0] mask_q, mask_d;
   logic [3:0] row_q, row_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       hit;
   logic       hold_drv, gap_drv, drive;
   colrow_t    cr;

`ifdef KEYPAD_BOUNCE_EN
   logic [3:0] bnc_q, bnc_d;
   logic       bwin;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      mask_d  = mask_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cr      = key_to_colrow(cmd.cmd_key);
      hit     = (key_col == col_q);
      cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               if (cr.valid) begin
                  state_d = ARM;
                  col_d   = cr.col;
                  mask_d  = cr.row;
                  cnt_d   = '0;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end
         ARM: begin
            if (hit) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Row drive looks at next-cycle state so rows drop exactly on HOLD exit.
   always_comb begin
`ifdef KEYPAD_BOUNCE_EN
      bnc_d    = (state_d != state_q) ? 4'd0 : bnc_q + 4'd1;
      bwin     = (cnt_d < cnt_t'(BOUNCE_CYCLES));
      hold_drv = !bwin || bnc_d[3];
      gap_drv  = bwin && bnc_d[3];
`else
      hold_drv = 1'b1;
      gap_drv  = 1'b0;
`endif
      drive = hit && (((state_d == HOLD) && hold_drv) ||
                      ((state_d == GAP) && gap_drv));
      row_d = drive ? mask_d : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         col_q   <= NO_SCAN;
         mask_q  <= 4'b0000;
         row_q   <= 4'b0000;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
         bnc_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         mask_q  <= mask_d;
         row_q   <= row_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef KEYPAD_BOUNCE_EN
         bnc_q   <= bnc_d;
`endif
      end
   end

   assign key_row       = row_q;
   assign busy          = (state_q != IDLE);
   assign cmd.cmd_ready = (state_q == IDLE);
   assign done_pulse    = done_q;
   assign err_pulse     = err_q;

endmodule

// File: tb/tb_keypad_responder.sv
// Directed bench for keypad_responder with shortened timing parameters.
module tb_keypad_responder;
   import keypad_pkg::*;

   localparam int H = 40;
   localparam int G = 12;
   localparam int T = 30;
   localparam int B = 32;

   logic       clk;
   logic       rst;
   logic [2:0] key_col;
   logic [3:0] key_row;
   logic       busy;
   logic       done_pulse;
   logic       err_pulse;
   int         checks;
   int         failures;

   keypad_cmd_if cmd_if ();

   keypad_responder #(
      .HOLD_CYCLES    (H),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (T),
      .BOUNCE_CYCLES  (B)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd        (cmd_if),
      .key_col    (key_col),
      .key_row    (key_row),
      .busy       (busy),
      .done_pulse (done_pulse),
      .err_pulse  (err_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] colpat(input int n);
      logic [2:0] p [3];
      p[0] = COLUMN1;
      p[1] = COLUMN2;
      p[2] = COLUMN3;
      return p[(n / 4) % 3];
   endfunction

   initial begin
      int         n;
      int         ms;
      int         hc;
      int         guard;
      logic [2:0] c;
      logic [3:0] exp_row;
      logic       saw;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      key_col  = NO_SCAN;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_key   = 4'd0;
      step();
      step();
      chk("rst_ready", cmd_if.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_row", key_row, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_err", err_pulse, 0);
      rst = 1'b0;
      step();

      // invalid code 13
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = 4'd13;
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("inv_err", err_pulse, 1);
      chk("inv_busy", busy, 0);
      chk("inv_row", key_row, 0);
      chk("inv_ready", cmd_if.cmd_ready, 1);
      step();
      chk("inv_err_clr", err_pulse, 0);
      chk("inv_busy2", busy, 0);

      // timeout: key 1, no scan
      key_col = NO_SCAN;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = 4'd1;
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("to_busy", busy, 1);
      chk("to_ready", cmd_if.cmd_ready, 0);
      saw = 1'b0;
      for (int i = 1; i < T; i++) begin
         step();
         if (err_pulse || !busy || key_row != 4'b0000) saw = 1'b1;
      end
      chk("to_wait_quiet", saw, 0);
      step();
      chk("to_err", err_pulse, 1);
      chk("to_busy_clr", busy, 0);
      chk("to_row", key_row, 0);

`ifndef KEYPAD_BOUNCE_EN
      // key 5 with cycling scanner
      n = 0;
      key_col = colpat(n);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = 4'd5;
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("k5_row_acc", key_row, 0);
      n++;
      key_col = colpat(n);
      ms = 0;
      hc = 0;
      guard = 0;
      while (ms != 2 && guard < 200) begin
         c = key_col;
         step();
         guard++;
         if (ms == 0) begin
            if (c == COLUMN2) begin
               exp_row = 4'b0010;
               ms = 1;
               hc = 0;
            end else begin
               exp_row = 4'b0000;
            end
         end else if (hc == H - 1) begin
            exp_row = 4'b0000;
            ms = 2;
         end else begin
            hc++;
            exp_row = (c == COLUMN2) ? 4'b0010 : 4'b0000;
         end
         chk("k5_row", key_row, exp_row);
         chk("k5_done_early", done_pulse, 0);
         n++;
         key_col = colpat(n);
      end
      chk("k5_reached_gap", ms, 2);
      for (int j = 1; j < G; j++) begin
         step();
         chk("k5_gap_row", key_row, 0);
         chk("k5_gap_done", done_pulse, 0);
         key_col = colpat(j);
      end
      step();
      chk("k5_done", done_pulse, 1);
      chk("k5_ready", cmd_if.cmd_ready, 1);
      step();
      chk("k5_done_clr", done_pulse, 0);

      // '#' with frozen scanner; a command waits through the press
      key_col = COLUMN3;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = KEY_HASH;
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("hash_row_acc", key_row, 0);
      saw = 1'b0;
      for (int j = 0; j < H; j++) begin
         step();
         if (key_row != 4'b1000 || cmd_if.cmd_ready) saw = 1'b1;
      end
      chk("hash_hold_steady", saw, 0);
      saw = 1'b0;
      for (int j = 0; j < G; j++) begin
         step();
         if (key_row != 4'b0000 || cmd_if.cmd_ready || done_pulse ||
             err_pulse) saw = 1'b1;
         cmd_if.cmd_valid = 1'b1;
         cmd_if.cmd_key   = 4'd14;
      end
      chk("hash_gap_quiet", saw, 0);
      step();
      chk("hash_done", done_pulse, 1);
      chk("hash_pending_err", err_pulse, 0);
      chk("hash_ready", cmd_if.cmd_ready, 1);
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("hash_held_cmd_err", err_pulse, 1);
      chk("hash_done_clr", done_pulse, 0);
      step();

      // reset during HOLD for key 7
      key_col = COLUMN1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = 4'd7;
      step();
      cmd_if.cmd_valid = 1'b0;
      step();
      chk("k7_row_first", key_row, 4'b0100);
      for (int j = 0; j < 5; j++) step();
      chk("k7_row_mid", key_row, 4'b0100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("k7_rst_row", key_row, 0);
      chk("k7_rst_ready", cmd_if.cmd_ready, 1);
      chk("k7_rst_busy", busy, 0);
      chk("k7_rst_done", done_pulse, 0);
      key_col = NO_SCAN;
      saw = 1'b0;
      for (int j = 0; j < H + G + 5; j++) begin
         step();
         if (done_pulse || err_pulse || key_row != 4'b0000) saw = 1'b1;
      end
      chk("k7_after_rst_quiet", saw, 0);
`else
      // key 2 with bounce, column held
      key_col = COLUMN2;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_key   = 4'd2;
      step();
      cmd_if.cmd_valid = 1'b0;
      chk("b_row_acc", key_row, 0);
      for (int j = 0; j < H; j++) begin
         step();
         exp_row = (j >= B || (j % 16) >= 8) ? 4'b0001 : 4'b0000;
         chk("b_hold_row", key_row, exp_row);
      end
      for (int j = 0; j < G; j++) begin
         step();
         exp_row = (j < B && (j % 16) >= 8) ? 4'b0001 : 4'b0000;
         chk("b_gap_row", key_row, exp_row);
      end
      step();
      chk("b_done", done_pulse, 1);
      chk("b_row_end", key_row, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
